// File: rtl/mem_pkg.sv
// Shared memory-access types: transfer size encodings and FSM state enum
// for the uncached bus unit, plus the request fault check.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_e;

    // A request faults if flagged upstream, uses the reserved size,
    // or is not naturally aligned for its size.
    function automatic logic access_fault(
        input logic       exc,
        input logic [1:0] size,
        input logic [1:0] lsb
    );
        logic f;
        f = exc;
        f = f | (size == SIZE_RSVD);
        f = f | ((size == SIZE_WORD) && (lsb != 2'b00));
        f = f | ((size == SIZE_HALF) && lsb[0]);
        return f;
    endfunction

endpackage

// File: rtl/uncached_bus_unit_if.sv
// Pipeline request/response and bus signals of the uncached bus unit.
// slave: the unit itself; master: pipeline plus bus side driving it.
interface uncached_bus_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [1:0]  req_size;
    logic        req_except;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [1:0]  bus_size;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata,
        input  req_wstrb, req_size, req_except,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output bus_req, bus_we, bus_addr, bus_wdata,
        output bus_wstrb, bus_size,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport master (
        output req_valid, req_addr, req_write, req_wdata,
        output req_wstrb, req_size, req_except,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_wstrb, bus_size,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

endinterface

// File: rtl/uncached_bus_unit.sv
// Single-outstanding uncached load/store unit: IDLE -> REQ -> WAIT -> RESP.
// Ports: clk, rst (sync, active high), bif (uncached_bus_unit_if.slave).
module uncached_bus_unit
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    uncached_bus_unit_if.slave bif
);

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic accept;
    logic fault;

    assign accept = bif.req_valid && (state_q == IDLE);
    assign fault  = access_fault(bif.req_except, bif.req_size,
                                 bif.req_addr[1:0]);

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bif.req_valid) begin
                    if (fault) begin
                        state_d = RESP;
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bif.bus_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (bif.bus_rvalid) begin
                    state_d = RESP;
                    rdata_d = we_q ? 32'h0 : bif.bus_rdata;
                    err_d   = bif.bus_err;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            size_q  <= 2'b00;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                addr_q  <= bif.req_addr;
                we_q    <= bif.req_write;
                wdata_q <= bif.req_wdata;
                wstrb_q <= bif.req_wstrb;
                size_q  <= bif.req_size;
            end
        end
    end

    logic in_req;
    assign in_req = (state_q == REQ);

    assign bif.req_ready  = (state_q == IDLE);
    assign bif.resp_valid = (state_q == RESP);
    assign bif.resp_rdata = rdata_q;
    assign bif.resp_err   = err_q;

    // Control qualifiers are gated to zero outside the address phase.
    assign bif.bus_req   = in_req;
    assign bif.bus_we    = in_req & we_q;
    assign bif.bus_wstrb = in_req ? wstrb_q : 4'h0;
    assign bif.bus_size  = in_req ? size_q : 2'b00;
    assign bif.bus_addr  = addr_q;
    assign bif.bus_wdata = wdata_q;

endmodule

// File: tb/tb_uncached_bus_unit.sv
// Self-checking bench for uncached_bus_unit: vector table plus
// hand sequences, responses checked against a scoreboard queue.
module tb_uncached_bus_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uncached_bus_unit_if bif ();

    uncached_bus_unit dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  size;
        logic        exc;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] brdata;
        logic        berr;
        logic        fault;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    vec_t  vecs[10];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bif.resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    resp_t e;
                    e = sb.pop_front();
                    chk("resp_rdata", bif.resp_rdata, e.rdata);
                    chk("resp_err", {31'h0, bif.resp_err}, {31'h0, e.err});
                end
            end
            if (!bif.bus_req)
                chk("bus_ctl_idle",
                    {25'h0, bif.bus_we, bif.bus_wstrb, bif.bus_size}, 32'h0);
        end
    end

    task automatic drive_req(input vec_t v);
        bif.req_valid  = 1'b1;
        bif.req_addr   = v.addr;
        bif.req_write  = v.wr;
        bif.req_wdata  = v.wdata;
        bif.req_wstrb  = v.wstrb;
        bif.req_size   = v.size;
        bif.req_except = v.exc;
    endtask

    task automatic scramble_req();
        bif.req_valid  = 1'b0;
        bif.req_addr   = $urandom;
        bif.req_write  = 1'($urandom);
        bif.req_wdata  = $urandom;
        bif.req_wstrb  = 4'($urandom);
        bif.req_size   = 2'($urandom);
        bif.req_except = 1'($urandom);
    endtask

    task automatic run_txn(input vec_t v);
        @(negedge clk);
        chk("ready_idle", {31'h0, bif.req_ready}, 32'd1);
        drive_req(v);
        sb.push_back('{v.exp_rdata, v.exp_err});
        @(negedge clk);
        scramble_req();
        if (v.fault) begin
            chk("fault_resp_t1", {31'h0, bif.resp_valid}, 32'd1);
            chk("fault_no_bus", {31'h0, bif.bus_req}, 32'd0);
        end else begin
            for (int i = 0; i <= v.gnt_dly; i++) begin
                chk("bus_req", {31'h0, bif.bus_req}, 32'd1);
                chk("bus_addr", bif.bus_addr, v.addr);
                chk("bus_we", {31'h0, bif.bus_we}, {31'h0, v.wr});
                chk("bus_wdata", bif.bus_wdata, v.wdata);
                chk("bus_wstrb", {28'h0, bif.bus_wstrb}, {28'h0, v.wstrb});
                chk("bus_size", {30'h0, bif.bus_size}, {30'h0, v.size});
                chk("ready_busy", {31'h0, bif.req_ready}, 32'd0);
                bif.bus_gnt    = (i == v.gnt_dly);
                bif.bus_rvalid = (i != v.gnt_dly);
                bif.bus_err    = 1'b1;
                bif.bus_rdata  = 32'hBAD0BAD0;
                @(negedge clk);
            end
            bif.bus_gnt = 1'b0;
            for (int i = 0; i <= v.rv_dly; i++) begin
                chk("wait_no_bus", {31'h0, bif.bus_req}, 32'd0);
                chk("wait_no_resp", {31'h0, bif.resp_valid}, 32'd0);
                bif.bus_rvalid = (i == v.rv_dly);
                bif.bus_rdata  = (i == v.rv_dly) ? v.brdata : $urandom;
                bif.bus_err    = (i == v.rv_dly) ? v.berr : 1'b1;
                @(negedge clk);
            end
            bif.bus_rvalid = 1'b0;
            bif.bus_err    = 1'b0;
            chk("resp_pulse", {31'h0, bif.resp_valid}, 32'd1);
        end
        @(negedge clk);
        chk("resp_once", {31'h0, bif.resp_valid}, 32'd0);
        chk("ready_after", {31'h0, bif.req_ready}, 32'd1);
        chk("rdata_hold", bif.resp_rdata, v.exp_rdata);
        chk("err_hold", {31'h0, bif.resp_err}, {31'h0, v.exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t f1, f2, l1;
        vecs[0] = '{32'h1FC00004, 1'b0, 32'h0, 4'h0, 2'b10, 1'b0, 0, 0,
                    32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{32'h1FD003F8, 1'b1, 32'h000000A5, 4'b0001, 2'b00, 1'b0,
                    3, 0, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{32'h00001000, 1'b0, 32'h0, 4'h0, 2'b10, 1'b1, 0, 0,
                    32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
        vecs[3] = '{32'h00000002, 1'b0, 32'h0, 4'h0, 2'b10, 1'b0, 0, 0,
                    32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
        vecs[4] = '{32'h00001001, 1'b1, 32'h0000FF00, 4'b0011, 2'b01, 1'b0,
                    0, 0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
        vecs[5] = '{32'h00002000, 1'b0, 32'h0, 4'h0, 2'b11, 1'b0, 0, 0,
                    32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
        vecs[6] = '{32'h00001002, 1'b0, 32'h0, 4'h0, 2'b01, 1'b0, 1, 2,
                    32'h0000BEEF, 1'b0, 1'b0, 32'h0000BEEF, 1'b0};
        vecs[7] = '{32'h00000100, 1'b1, 32'h55AA55AA, 4'hF, 2'b10, 1'b0,
                    0, 1, 32'h77777777, 1'b1, 1'b0, 32'h0, 1'b1};
        vecs[8] = '{32'h00000200, 1'b0, 32'h0, 4'h0, 2'b10, 1'b0, 2, 0,
                    32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1};
        vecs[9] = '{32'h00000003, 1'b0, 32'h0, 4'h0, 2'b00, 1'b0, 0, 0,
                    32'h00000011, 1'b0, 1'b0, 32'h00000011, 1'b0};

        scramble_req();
        bif.bus_gnt    = 1'b0;
        bif.bus_rvalid = 1'b0;
        bif.bus_rdata  = 32'h0;
        bif.bus_err    = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, bif.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'h0, bif.resp_valid}, 32'd0);
        chk("rst_rdata", bif.resp_rdata, 32'h0);
        chk("rst_err", {31'h0, bif.resp_err}, 32'd0);
        chk("rst_bus_req", {31'h0, bif.bus_req}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Request held during RESP is accepted only the cycle after.
        f1 = vecs[2];
        f2 = vecs[3];
        @(negedge clk);
        drive_req(f1);
        sb.push_back('{32'h0, 1'b1});
        @(negedge clk);
        chk("b2b_resp", {31'h0, bif.resp_valid}, 32'd1);
        chk("b2b_ready_resp", {31'h0, bif.req_ready}, 32'd0);
        drive_req(f2);
        sb.push_back('{32'h0, 1'b1});
        @(negedge clk);
        chk("b2b_gap", {31'h0, bif.resp_valid}, 32'd0);
        chk("b2b_ready", {31'h0, bif.req_ready}, 32'd1);
        @(negedge clk);
        scramble_req();
        chk("b2b_resp2", {31'h0, bif.resp_valid}, 32'd1);
        @(negedge clk);

        // Reset while in WAIT, then a stray rvalid.
        l1 = vecs[0];
        drive_req(l1);
        @(negedge clk);
        scramble_req();
        chk("rw_bus_req", {31'h0, bif.bus_req}, 32'd1);
        bif.bus_gnt = 1'b1;
        @(negedge clk);
        bif.bus_gnt = 1'b0;
        chk("rw_in_wait", {31'h0, bif.req_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_bus_off", {31'h0, bif.bus_req}, 32'd0);
        chk("rw_ready", {31'h0, bif.req_ready}, 32'd1);
        chk("rw_rdata_clr", bif.resp_rdata, 32'h0);
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'h13579BDF;
        @(negedge clk);
        bif.bus_rvalid = 1'b0;
        chk("rw_no_resp", {31'h0, bif.resp_valid}, 32'd0);
        chk("rw_ready2", {31'h0, bif.req_ready}, 32'd1);

        // Reset while in REQ, then a stray grant.
        drive_req(l1);
        @(negedge clk);
        scramble_req();
        chk("rr_bus_req", {31'h0, bif.bus_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr_bus_off", {31'h0, bif.bus_req}, 32'd0);
        chk("rr_ready", {31'h0, bif.req_ready}, 32'd1);
        bif.bus_gnt = 1'b1;
        @(negedge clk);
        bif.bus_gnt = 1'b0;
        chk("rr_still_idle", {31'h0, bif.bus_req}, 32'd0);
        chk("rr_no_resp", {31'h0, bif.resp_valid}, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uncached_bus_unit.md
UNCACHED_BUS_UNIT -- requirements
Module: uncached_bus_unit

Interface
REQ-001 The block SHALL have no parameters; bus data width is fixed at 32, address width at 32.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with the ports listed below.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  pipeline request present; driven by the address-mapping stage.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_addr  input  32  physical address, already mapped.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_wdata  input  32  store data, lane-aligned.
REQ-010 req_wstrb  input  4  store byte enables.
REQ-011 req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-012 req_except  input  1  user-mode address violation flagged upstream.
REQ-013 resp_valid  output  1  one-cycle completion pulse.
REQ-014 resp_rdata  output  32  load data, valid with resp_valid.
REQ-015 resp_err  output  1  access faulted, valid with resp_valid.
REQ-016 bus_req  output  1  bus address phase request.
REQ-017 bus_we  output  1  bus write enable.
REQ-018 bus_addr  output  32  bus address.
REQ-019 bus_wdata  output  32  bus write data.
REQ-020 bus_wstrb  output  4  bus byte enables.
REQ-021 bus_size  output  2  bus transfer size, same encoding as req_size.
REQ-022 bus_gnt  input  1  address phase accepted this cycle.
REQ-023 bus_rvalid  input  1  data or completion phase, for both reads and writes.
REQ-024 bus_rdata  input  32  read data.
REQ-025 bus_err  input  1  bus error, qualified by bus_rvalid.

Function
REQ-026 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, RESP.
REQ-027 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0. Acceptance is the cycle where req_valid and req_ready are both 1.
REQ-028 On acceptance, the block SHALL register addr, write, wdata, wstrb and size.
- Faulting request (req_except=1; reserved size; word with addr[1:0]!=0; half with addr[0]=1): go to RESP with err=1; no bus activity.
- Otherwise: go to REQ.
REQ-029 In REQ, bus_req SHALL be 1 with bus_* driven from the registered request; the state SHALL be held until bus_gnt=1, then go to WAIT.
REQ-030 The request SHALL remain stable while bus_req=1.
REQ-031 bus_rvalid SHALL be ignored outside WAIT; bus_rvalid is never asserted in the same cycle as its bus_gnt.
REQ-032 In WAIT, on bus_rvalid=1 the block SHALL capture the response and go to RESP.
- err = bus_err.
- rdata = bus_rdata for loads, 0 for stores.
REQ-033 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the state SHALL go to IDLE; no backpressure on the response.
REQ-034 resp_rdata and resp_err SHALL be driven from registers and SHALL hold their values until the next RESP.
REQ-035 Minimum latency for a bus access (gnt same cycle as bus_req, rvalid next cycle) SHALL be: accept T, bus_req T+1, resp_valid T+3.
REQ-036 Minimum latency for a faulting request SHALL be: resp_valid T+1.
REQ-037 At most one transaction SHALL be outstanding; back-to-back requests are accepted at the earliest in the cycle after RESP.
REQ-038 When bus_req=0, bus_we, bus_wstrb and bus_size SHALL be 0.

Reset
REQ-039 On rst=1, the block SHALL enter IDLE on the next edge; reset values: resp_valid=0, resp_rdata=0, resp_err=0, bus_req=0, req_ready=1 after reset.
REQ-040 Reset during REQ or WAIT SHALL abandon the transaction with no response; bus_req SHALL be 0 in the cycle after reset; any late bus_rvalid SHALL be ignored.

Structure
REQ-041 The shared package mem_pkg SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state enum.
REQ-042 The block SHALL have no sub-module; it is a single FSM plus request/response registers.

Verification
REQ-043 Read: word load at 0x1FC00004, gnt immediate, rvalid one cycle later with data 0xDEADBEEF -> resp_valid at T+3, rdata=0xDEADBEEF, err=0.
REQ-044 Write stall: byte store at 0x1FD003F8 with wstrb=0001, gnt delayed 3 cycles -> bus_* stable throughout, req_ready=0, resp_valid once, rdata=0.
REQ-045 Faults: req_except=1, and separately word at 0x00000002 -> resp_valid at T+1, err=1, bus_req never asserted.
REQ-046 Bus error: rvalid with bus_err=1 -> resp_err=1; a new request is accepted the cycle after RESP.
REQ-047 Reset in WAIT: assert rst, then drive a stray bus_rvalid -> no resp_valid, state IDLE, req_ready=1.
